// File: rtl/stump_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : stump_mem_if
// Brief    : Stump memory bus interface: one req/ack transaction per control
//            strobe, holds IR/MDR, stalls control until completion.
//            Optional bus timeout abort enabled by STUMP_MEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stump_mem_if #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch,
    input  logic        memory,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack,
    output logic [15:0] ir,
    output logic [15:0] mdr,
    output logic        stall,
    output logic        bus_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_param_check
        $error("stump_mem_if: TIMEOUT_CYCLES must be in 2..255");
    end

    state_t      r_state;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [15:0] r_bus_addr;
    logic [15:0] r_bus_wdata;
    logic        r_to_ir;
    logic [15:0] r_ir;
    logic [15:0] r_mdr;
    logic        w_strobe;
    logic        w_timeout;

    assign w_strobe = mem_ren | mem_wen;

`ifdef STUMP_MEM_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_bus_err;

    // An ack in the same cycle as the last allowed cycle still completes normally.
    assign w_timeout = (r_state == BUSY) && !bus_ack && (r_cnt == c_TO_LAST);
    assign bus_err   = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 16'h0000;
            r_bus_wdata <= 16'h0000;
            r_to_ir     <= 1'b0;
            r_ir        <= 16'h0000;
            r_mdr       <= 16'h0000;
`ifdef STUMP_MEM_TIMEOUT_EN
            r_cnt       <= 8'd0;
            r_bus_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_strobe) begin
                        r_state     <= BUSY;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= mem_wen;
                        r_bus_addr  <= addr;
                        r_bus_wdata <= wdata;
                        r_to_ir     <= fetch;
`ifdef STUMP_MEM_TIMEOUT_EN
                        r_cnt       <= 8'd0;
`endif
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        r_state   <= IDLE;
                        r_bus_req <= 1'b0;
                        if (!r_bus_we) begin
                            if (r_to_ir) r_ir  <= bus_rdata;
                            else         r_mdr <= bus_rdata;
                        end
                    end
`ifdef STUMP_MEM_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state   <= IDLE;
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        if (!r_bus_we) begin
                            if (r_to_ir) r_ir  <= 16'h0000;
                            else         r_mdr <= 16'h0000;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Stall drops in the completing (or aborting) cycle so control advances on that edge.
    always_comb begin
        stall = 1'b0;
        if (r_state == IDLE) stall = w_strobe;
        else                 stall = !bus_ack && !w_timeout;
    end

    // memory is informational: kind is fully decided by fetch.
    logic w_unused;
    assign w_unused = memory;

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign ir        = r_ir;
    assign mdr       = r_mdr;

endmodule
`default_nettype wire

// File: tb/tb_stump_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_stump_mem_if
// Brief    : Directed self-checking bench for stump_mem_if.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stump_mem_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch, memory, mem_ren, mem_wen;
    logic [15:0] addr, wdata, bus_rdata;
    logic        bus_ack;
    logic        bus_req, bus_we, stall, bus_err;
    logic [15:0] bus_addr, bus_wdata, ir, mdr;

    int n_cmp = 0;
    int n_bad = 0;
    int stall_cnt;

    stump_mem_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .fetch(fetch), .memory(memory),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .addr(addr), .wdata(wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .ir(ir), .mdr(mdr), .stall(stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input logic f, input logic m, input logic r, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
        fetch = f; memory = m; mem_ren = r; mem_wen = w; addr = a; wdata = d;
    endtask

    initial begin
        rst = 1'b1; bus_ack = 1'b0; bus_rdata = 16'h0000;
        strobes(0, 0, 0, 0, 16'h0000, 16'h0000);
        tick(); tick();
        chk("rst_req", {15'd0, bus_req}, 16'd0);
        chk("rst_we", {15'd0, bus_we}, 16'd0);
        chk("rst_addr", bus_addr, 16'h0000);
        chk("rst_wdata", bus_wdata, 16'h0000);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_mdr", mdr, 16'h0000);
        chk("rst_err", {15'd0, bus_err}, 16'd0);
        chk("rst_stall", {15'd0, stall}, 16'd0);
        rst = 1'b0;
        tick();

        // Fetch, zero wait states
        strobes(1, 0, 1, 0, 16'h0010, 16'h0000);
        #1 chk("f_stall_idle", {15'd0, stall}, 16'd1);
        chk("f_req_idle", {15'd0, bus_req}, 16'd0);
        tick();
        chk("f_req_busy", {15'd0, bus_req}, 16'd1);
        chk("f_addr", bus_addr, 16'h0010);
        chk("f_we", {15'd0, bus_we}, 16'd0);
        bus_ack = 1'b1; bus_rdata = 16'hA5C3;
        #1 chk("f_stall_ack", {15'd0, stall}, 16'd0);
        tick();
        bus_ack = 1'b0; bus_rdata = 16'h0000;
        strobes(0, 0, 0, 0, 16'h0000, 16'h0000);
        chk("f_req_done", {15'd0, bus_req}, 16'd0);
        chk("f_ir", ir, 16'hA5C3);
        chk("f_mdr", mdr, 16'h0000);
        tick();

        // Load, three wait states
        strobes(0, 1, 1, 0, 16'h0200, 16'h0000);
        stall_cnt = 0;
        #1 if (stall) stall_cnt++;
        tick();
        strobes(0, 1, 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            #1 if (stall) stall_cnt++;
            chk("l_req", {15'd0, bus_req}, 16'd1);
            chk("l_addr", bus_addr, 16'h0200);
            tick();
        end
        bus_ack = 1'b1; bus_rdata = 16'h1234;
        #1 if (stall) stall_cnt++;
        chk("l_stall_cnt", 16'(stall_cnt), 16'd4);
        tick();
        bus_ack = 1'b0;
        strobes(0, 0, 0, 0, 16'h0000, 16'h0000);
        chk("l_mdr", mdr, 16'h1234);
        chk("l_ir", ir, 16'hA5C3);
        chk("l_req_done", {15'd0, bus_req}, 16'd0);
        tick();

        // Store, one wait state, read data on the bus must not be captured
        strobes(0, 1, 0, 1, 16'h0300, 16'hBEEF);
        tick();
        strobes(0, 0, 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            chk("s_we", {15'd0, bus_we}, 16'd1);
            chk("s_wdata", bus_wdata, 16'hBEEF);
            chk("s_addr", bus_addr, 16'h0300);
            if (i == 0) tick();
        end
        bus_ack = 1'b1; bus_rdata = 16'hFFFF;
        tick();
        bus_ack = 1'b0;
        chk("s_ir", ir, 16'hA5C3);
        chk("s_mdr", mdr, 16'h1234);
        tick();

        // Both strobes: write wins
        strobes(0, 1, 1, 1, 16'h0400, 16'h1111);
        tick();
        strobes(0, 0, 0, 0, 16'h0000, 16'h0000);
        chk("rw_we", {15'd0, bus_we}, 16'd1);
        chk("rw_wdata", bus_wdata, 16'h1111);
        bus_ack = 1'b1; bus_rdata = 16'hDEAD;
        tick();
        bus_ack = 1'b0;
        chk("rw_mdr", mdr, 16'h1234);
        tick();

        // Reset in the 2nd BUSY cycle of a delayed read
        strobes(0, 1, 1, 0, 16'h0500, 16'h0000);
        tick();
        tick();
        chk("r_req_pre", {15'd0, bus_req}, 16'd1);
        rst = 1'b1;
        strobes(0, 0, 0, 0, 16'h0000, 16'h0000);
        #1 chk("r_req_async", {15'd0, bus_req}, 16'd0);
        chk("r_addr", bus_addr, 16'h0000);
        chk("r_ir", ir, 16'h0000);
        chk("r_mdr", mdr, 16'h0000);
        chk("r_stall", {15'd0, stall}, 16'd0);
        tick();
        rst = 1'b0;
        bus_ack = 1'b1; bus_rdata = 16'h9999;
        tick();
        bus_ack = 1'b0;
        chk("r_late_ack_mdr", mdr, 16'h0000);
        chk("r_late_ack_req", {15'd0, bus_req}, 16'd0);
        tick();

        // Load a nonzero value so an abort's clearing of MDR is visible
        strobes(0, 1, 1, 0, 16'h0600, 16'h0000);
        tick();
        strobes(0, 0, 0, 0, 16'h0000, 16'h0000);
        bus_ack = 1'b1; bus_rdata = 16'h5A5A;
        tick();
        bus_ack = 1'b0;
        chk("p_mdr", mdr, 16'h5A5A);
        tick();

`ifdef STUMP_MEM_TIMEOUT_EN
        // Read with no ack: abort after 4 BUSY cycles
        strobes(0, 1, 1, 0, 16'h0700, 16'h0000);
        tick();
        strobes(0, 0, 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            chk("t_stall", {15'd0, stall}, 16'd1);
            tick();
        end
        chk("t_stall_abort", {15'd0, stall}, 16'd0);
        chk("t_err_pre", {15'd0, bus_err}, 16'd0);
        tick();
        chk("t_err", {15'd0, bus_err}, 16'd1);
        chk("t_mdr", mdr, 16'h0000);
        chk("t_req", {15'd0, bus_req}, 16'd0);
        tick();
        strobes(0, 1, 1, 0, 16'h0800, 16'h0000);
        tick();
        strobes(0, 0, 0, 0, 16'h0000, 16'h0000);
        bus_ack = 1'b1; bus_rdata = 16'h7777;
        tick();
        bus_ack = 1'b0;
        chk("t_next_mdr", mdr, 16'h7777);
        chk("t_err_sticky", {15'd0, bus_err}, 16'd1);
`else
        // Without the timeout a stalled read simply waits
        strobes(0, 1, 1, 0, 16'h0700, 16'h0000);
        tick();
        strobes(0, 0, 0, 0, 16'h0000, 16'h0000);
        repeat (20) tick();
        chk("n_stall_wait", {15'd0, stall}, 16'd1);
        chk("n_req_wait", {15'd0, bus_req}, 16'd1);
        bus_ack = 1'b1; bus_rdata = 16'h7777;
        tick();
        bus_ack = 1'b0;
        chk("n_mdr", mdr, 16'h7777);
        chk("n_err", {15'd0, bus_err}, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
